if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage that replaces the single-register PC/instruction path with a PC generator feeding a DEPTH-entry fetch queue toward decode. It drives a combinational instruction memory, buffers {pc, instr} pairs, and presents them to decode over a valid/ready handshake. Fetch stalls when the queue is full. A redirect from execute flushes the queue and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4: fetch-queue entries; power of two, ≥ 2.
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset (sampled on posedge clk).
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_addr  out  32  fetch address to imem, equal to the internal PC register.
- imem_rdata  in  32  instruction word at imem_addr, combinational, same cycle.
- out_valid  out  1  queue head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.

## Operation
- State: PC register; circular queue of DEPTH {pc, instr} entries; read pointer, write pointer, and occupancy count.
- pop = out_valid & out_ready.
- push = ~redirect_valid & (occupancy < DEPTH | pop). Writes {PC, imem_rdata} at the write pointer.
- PC update priority at each posedge:
  - reset: PC = RESET_PC.
  - else redirect_valid: PC = {redirect_pc[31:2], 2'b00}.
  - else push: PC = PC + 4. 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - else: PC holds.
- Queue update priority at each posedge:
  - reset or redirect_valid: pointers and occupancy cleared. A same-cycle pop is ignored.
  - else: pointers advance independently on push and pop; occupancy += push − pop.
- Push and pop in the same cycle with a full queue is legal; occupancy stays DEPTH.
- Push and pop in the same cycle with an empty queue is impossible, because out_valid = 0.
- Pointers wrap modulo DEPTH.
- out_valid = (occupancy != 0). out_pc and out_instr are read combinationally from the entry at the read pointer.
- out_pc and out_instr are don't-care when out_valid = 0.
- When out_valid = 1 and out_ready = 0, the head entry must hold stable.
- Entries are delivered to decode in strictly increasing-by-4 PC order between redirects.

## Timing
- Reset values (after any posedge with reset = 1):
  - imem_addr = RESET_PC.
  - out_valid = 0.
  - occupancy = 0.
- Reset asserted mid-operation discards all queued entries at that edge. No partial state survives.
- First fetch: at the first posedge with reset = 0, entry RESET_PC is pushed. out_valid rises the same edge, so it is visible in the following cycle.
- Steady state with out_ready held at 1: one instruction per cycle. out_pc advances by 4 each cycle.
- Stall: with out_ready = 0, the queue fills in DEPTH cycles. imem_addr then holds at RESET_PC + 4·DEPTH until a pop occurs.
- Redirect latency, with redirect_valid sampled high at edge E:
  - out_valid = 0 and imem_addr = target after E.
  - The target entry is pushed at E+1 and is visible after E+1.
  - This gives a one-cycle bubble at the decode interface.
- Back-to-back redirects: the last one wins. No push occurs on any cycle with redirect_valid = 1.
- reset and redirect_valid together: reset wins.

## Test plan
- Reset then free-run (out_ready = 1, RESET_PC = 0): out_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles. out_instr matches imem contents at each address.
- Backpressure (DEPTH = 4, out_ready = 0 after reset): occupancy reaches 4. imem_addr then holds at 0x10. Raising out_ready drains 0x0, 0x4, 0x8, 0xC, 0x10 in order with no gaps and no duplicates.
- Full plus pop: with the queue full, hold out_ready = 1. Occupancy must stay 4 and a new PC must be pushed every cycle.
- Redirect: with 3 entries queued, pulse redirect_valid with redirect_pc = 0x103.
  - The next cycle shows out_valid = 0 and imem_addr = 0x100.
  - The cycle after shows out_pc = 0x100.
  - Then out_pc = 0x104.
  - No pre-redirect entries appear.
- Reset mid-stream: assert reset for one cycle with the queue partially full and RESET_PC = 0x80. Required: out_valid = 0, then out_pc = 0x80, then 0x84.
- Wrap and priority:
  - Redirect to 0xFFFF_FFFC: required out_pc sequence is 0xFFFF_FFFC, then 0x0000_0000.
  - Assert reset and redirect_valid together: PC = RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generator driving a combinational imem, buffering
// {pc, instr} pairs in a DEPTH-entry circular queue presented to decode via valid/ready.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    logic [31:0]   pc_q;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] count;
    logic          full;
    logic          pop;
    logic          push;
    logic [31:0]   redirect_target;

    assign full            = (count == OW'(DEPTH));
    assign out_valid       = (count != '0);
    assign pop             = out_valid & out_ready;
    // A full queue can still accept a new entry when the head leaves this cycle.
    assign push            = ~redirect_valid & (~full | pop);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_addr = pc_q;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_target;
        end else if (push) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_q;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue: two instances (RESET_PC 0 and 0x80)
// share stimulus; imem is a fixed address-derived pattern.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] a_imem_addr, a_imem_rdata, a_out_pc, a_out_instr;
    logic        a_out_valid;
    logic [2:0]  a_occupancy;
    logic [31:0] b_imem_addr, b_imem_rdata, b_out_pc, b_out_instr;
    logic        b_out_valid;
    logic [2:0]  b_occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[31:16]};
    endfunction

    assign a_imem_rdata = mem_word(a_imem_addr);
    assign b_imem_rdata = mem_word(b_imem_addr);

    if_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr), .occupancy(a_occupancy)
    );

    if_fetch_queue #(.RESET_PC(32'h0000_0080), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr), .occupancy(b_occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step(); step();
        checks++; if (a_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", a_imem_addr, 32'h0); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_out_valid); end
        checks++; if (a_occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", a_occupancy); end
        checks++; if (b_imem_addr !== 32'h80) begin errors++; $display("FAIL reset_addr_b got %h exp %h", b_imem_addr, 32'h80); end
    endtask

    task automatic test_free_run();
        reset = 1'b0; out_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL run_valid[%0d] got %b exp 1", i, a_out_valid); end
            checks++; if (a_out_pc !== 32'(4 * i)) begin errors++; $display("FAIL run_pc[%0d] got %h exp %h", i, a_out_pc, 32'(4 * i)); end
            checks++; if (a_out_instr !== mem_word(32'(4 * i))) begin errors++; $display("FAIL run_instr[%0d] got %h exp %h", i, a_out_instr, mem_word(32'(4 * i))); end
            checks++; if (a_occupancy !== 3'd1) begin errors++; $display("FAIL run_occ[%0d] got %0d exp 1", i, a_occupancy); end
            step();
        end
    endtask

    task automatic test_backpressure();
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (a_occupancy !== 3'(i)) begin errors++; $display("FAIL fill_occ[%0d] got %0d exp %0d", i, a_occupancy, i); end
        end
        step(); step();
        checks++; if (a_imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr got %h exp %h", a_imem_addr, 32'h10); end
        checks++; if (a_occupancy !== 3'd4) begin errors++; $display("FAIL stall_occ got %0d exp 4", a_occupancy); end
        checks++; if (a_out_pc !== 32'h0) begin errors++; $display("FAIL stall_head got %h exp 0", a_out_pc); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (a_out_pc !== 32'(4 * k)) begin errors++; $display("FAIL drain_pc[%0d] got %h exp %h", k, a_out_pc, 32'(4 * k)); end
            checks++; if (a_occupancy !== 3'd4) begin errors++; $display("FAIL full_pop_occ[%0d] got %0d exp 4", k, a_occupancy); end
            checks++; if (a_imem_addr !== 32'(16 + 4 * k)) begin errors++; $display("FAIL full_pop_addr[%0d] got %h exp %h", k, a_imem_addr, 32'(16 + 4 * k)); end
            step();
        end
    endtask

    task automatic test_redirect();
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0;
        step(); step(); step();
        checks++; if (a_occupancy !== 3'd3) begin errors++; $display("FAIL pre_redir_occ got %0d exp 3", a_occupancy); end
        redirect_valid = 1'b1; redirect_pc = 32'h103; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b exp 0", a_out_valid); end
        checks++; if (a_imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h exp %h", a_imem_addr, 32'h100); end
        step();
        checks++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h100) begin errors++; $display("FAIL redir_pc0 got %b/%h exp 1/%h", a_out_valid, a_out_pc, 32'h100); end
        checks++; if (a_out_instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_instr got %h exp %h", a_out_instr, mem_word(32'h100)); end
        step();
        checks++; if (a_out_pc !== 32'h104) begin errors++; $display("FAIL redir_pc1 got %h exp %h", a_out_pc, 32'h104); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        step(); step();
        checks++; if (a_occupancy !== 3'd3) begin errors++; $display("FAIL mid_occ got %0d exp 3", a_occupancy); end
        reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b1;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_b got %b exp 0", b_out_valid); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_a got %b exp 0", a_out_valid); end
        checks++; if (b_imem_addr !== 32'h80) begin errors++; $display("FAIL mid_addr_b got %h exp %h", b_imem_addr, 32'h80); end
        step();
        checks++; if (b_out_valid !== 1'b1 || b_out_pc !== 32'h80) begin errors++; $display("FAIL mid_pc0_b got %b/%h exp 1/%h", b_out_valid, b_out_pc, 32'h80); end
        checks++; if (a_out_pc !== 32'h0) begin errors++; $display("FAIL mid_pc0_a got %h exp 0", a_out_pc); end
        step();
        checks++; if (b_out_pc !== 32'h84) begin errors++; $display("FAIL mid_pc1_b got %h exp %h", b_out_pc, 32'h84); end
        checks++; if (a_out_pc !== 32'h4) begin errors++; $display("FAIL mid_pc1_a got %h exp %h", a_out_pc, 32'h4); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        checks++; if (a_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp %h", a_imem_addr, 32'hFFFF_FFFC); end
        step();
        checks++; if (a_out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp %h", a_out_pc, 32'hFFFF_FFFC); end
        checks++; if (a_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h exp 0", a_imem_addr); end
        step();
        checks++; if (a_out_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %h exp 0", a_out_pc); end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_occupancy !== 3'd0) begin errors++; $display("FAIL b2b_empty got %b/%0d exp 0/0", a_out_valid, a_occupancy); end
        checks++; if (a_imem_addr !== 32'h300) begin errors++; $display("FAIL b2b_addr got %h exp %h", a_imem_addr, 32'h300); end
        step();
        checks++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h300) begin errors++; $display("FAIL b2b_pc got %b/%h exp 1/%h", a_out_valid, a_out_pc, 32'h300); end
    endtask

    task automatic test_reset_redirect();
        out_ready = 1'b0;
        step();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        step();
        reset = 1'b0; redirect_valid = 1'b0;
        checks++; if (a_imem_addr !== 32'h0) begin errors++; $display("FAIL rr_addr_a got %h exp 0", a_imem_addr); end
        checks++; if (b_imem_addr !== 32'h80) begin errors++; $display("FAIL rr_addr_b got %h exp %h", b_imem_addr, 32'h80); end
        checks++; if (a_occupancy !== 3'd0) begin errors++; $display("FAIL rr_occ got %0d exp 0", a_occupancy); end
        step();
        checks++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h0) begin errors++; $display("FAIL rr_pc got %b/%h exp 1/0", a_out_valid, a_out_pc); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_reset_midstream();
        test_wrap();
        test_back_to_back();
        test_reset_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
